// File: rtl/spi_seq_pkg.sv
// Shared encodings for the SPI register sequencer: FSM states, frame op codes,
// sticky flag positions and the timeout filler word.
package spi_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_REQ,
        ST_WAIT,
        ST_COMMIT
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_STAT = 2'b11
    } op_e;

    localparam int FLAG_ERR = 0;
    localparam int FLAG_TO  = 1;
    localparam int FLAG_OVR = 2;

    localparam logic [31:0] PEND_TIMEOUT = 32'hDEAD_DEAD;

    function automatic logic [31:0] status_word(input logic [7:0] tag,
                                                input logic [2:0] flags,
                                                input logic       busy);
        return {tag, 20'h0, flags[FLAG_OVR], flags[FLAG_TO], flags[FLAG_ERR], busy};
    endfunction

endpackage

// File: rtl/spi_seq_sync.sv
// Two-flop synchroniser for the SPI chip select plus a one-cycle pulse on its rising edge.
module spi_seq_sync (
    input  logic clk_i,
    input  logic reset_i,
    input  logic ss_async_i,
    output logic ss_high_o,
    output logic frame_end_o
);

    logic ss_meta_q;
    logic ss_sync_q;
    logic ss_prev_q;

    // Reset to the idle (deselected) level so releasing reset never fakes a frame end.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ss_meta_q <= 1'b1;
            ss_sync_q <= 1'b1;
            ss_prev_q <= 1'b1;
        end else begin
            ss_meta_q <= ss_async_i;
            ss_sync_q <= ss_meta_q;
            ss_prev_q <= ss_sync_q;
        end
    end

    assign ss_high_o   = ss_sync_q;
    assign frame_end_o = ss_sync_q & ~ss_prev_q;

endmodule

// File: rtl/spi_reg_sequencer.sv
// Converts SPI frames into single-word system bus reads/writes and returns data/status.
// state   | meaning
// IDLE    | waiting for a frame end
// CAPTURE | two cycles before sampling the SPI words, then launch or drop
// REQ     | bus_req high until granted
// WAIT    | granted, waiting for the response
// COMMIT  | result in pend, copied to reg_dout once SS is high
module spi_reg_sequencer
    import spi_seq_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 24,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    ss_async_i,
    input  logic [DATA_WIDTH-1:0]   reg_addr_i,
    input  logic [DATA_WIDTH-1:0]   reg_din_i,
    output logic                    bus_req_o,
    input  logic                    bus_gnt_i,
    output logic                    bus_we_o,
    output logic [ADDR_WIDTH-1:0]   bus_addr_o,
    output logic [DATA_WIDTH-1:0]   bus_wdata_o,
    output logic [DATA_WIDTH/8-1:0] bus_be_o,
    input  logic                    bus_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   bus_rdata_i,
    input  logic                    bus_err_i,
    output logic [DATA_WIDTH-1:0]   reg_dout_o,
    output logic                    busy_o
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC);

    logic ss_high;
    logic frame_end;

    spi_seq_sync u_sync (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .ss_async_i  (ss_async_i),
        .ss_high_o   (ss_high),
        .frame_end_o (frame_end)
    );

    state_e                  state_q;
    logic                    cap_cnt_q;
    logic [TMO_W-1:0]        tmo_q;
    logic [7:0]              last_tag_q;
    logic [2:0]              flags_q, flags_d;
    logic                    is_stat_q;
    logic [DATA_WIDTH-1:0]   pend_q;
    logic                    bus_req_q, bus_we_q, busy_q;
    logic [ADDR_WIDTH-1:0]   bus_addr_q;
    logic [DATA_WIDTH-1:0]   bus_wdata_q, reg_dout_q;

    logic [7:0] cap_tag;
    op_e        cap_op;
    logic       timeout_hit;

    assign cap_tag     = reg_addr_i[DATA_WIDTH-1 -: 8];
    assign cap_op      = op_e'(reg_addr_i[1:0]);
    assign timeout_hit = (tmo_q == '0) &&
                         ((state_q == ST_REQ) || (state_q == ST_WAIT && !bus_rvalid_i));

    // Clear-on-status-commit first, so a flag raised in that same cycle survives.
    always_comb begin
        flags_d = flags_q;
        if (state_q == ST_COMMIT && ss_high && is_stat_q) flags_d = '0;
        if (frame_end && state_q != ST_IDLE)               flags_d[FLAG_OVR] = 1'b1;
        if (timeout_hit)                                   flags_d[FLAG_TO]  = 1'b1;
        if (state_q == ST_WAIT && bus_rvalid_i && bus_err_i) flags_d[FLAG_ERR] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            cap_cnt_q   <= 1'b0;
            tmo_q       <= '0;
            last_tag_q  <= '0;
            flags_q     <= '0;
            is_stat_q   <= 1'b0;
            pend_q      <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            reg_dout_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            flags_q <= flags_d;
            case (state_q)
                ST_IDLE: begin
                    if (frame_end) begin
                        state_q   <= ST_CAPTURE;
                        cap_cnt_q <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (!cap_cnt_q) begin
                        cap_cnt_q <= 1'b1;
                    end else if (cap_tag == last_tag_q || cap_op == OP_NOP) begin
                        state_q <= ST_IDLE;
                    end else begin
                        last_tag_q <= cap_tag;
                        busy_q     <= 1'b1;
                        is_stat_q  <= (cap_op == OP_STAT);
                        if (cap_op == OP_STAT) begin
                            pend_q  <= status_word(cap_tag, flags_d, busy_q);
                            state_q <= ST_COMMIT;
                        end else begin
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= (cap_op == OP_WR);
                            bus_addr_q  <= {reg_addr_i[ADDR_WIDTH-1:2], 2'b00};
                            bus_wdata_q <= reg_din_i;
                            tmo_q       <= TMO_W'(TIMEOUT_CYC - 1);
                            state_q     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (timeout_hit) begin
                        bus_req_q <= 1'b0;
                        pend_q    <= PEND_TIMEOUT;
                        state_q   <= ST_COMMIT;
                    end else begin
                        tmo_q <= tmo_q - 1'b1;
                        if (bus_gnt_i) begin
                            bus_req_q <= 1'b0;
                            state_q   <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus_rvalid_i) begin
                        if (!bus_we_q) pend_q <= bus_rdata_i;
                        state_q <= ST_COMMIT;
                    end else if (timeout_hit) begin
                        pend_q  <= PEND_TIMEOUT;
                        state_q <= ST_COMMIT;
                    end else begin
                        tmo_q <= tmo_q - 1'b1;
                    end
                end
                ST_COMMIT: begin
                    if (ss_high) begin
                        reg_dout_q <= pend_q;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_be_o    = '1;
    assign reg_dout_o  = reg_dout_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Directed bench for spi_reg_sequencer with a frame-level reference model and a per-cycle checker.
module tb_spi_reg_sequencer;

    localparam int TO = 16;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        ss_async_i;
    logic [31:0] reg_addr_i, reg_din_i;
    logic        bus_req_o, bus_gnt_i, bus_we_o;
    logic [23:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_rvalid_i, bus_err_i;
    logic [31:0] bus_rdata_i, reg_dout_o;
    logic        busy_o;

    spi_reg_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(24), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .ss_async_i(ss_async_i),
        .reg_addr_i(reg_addr_i), .reg_din_i(reg_din_i),
        .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
        .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i),
        .reg_dout_o(reg_dout_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, updated once per SPI frame.
    logic [7:0]  m_last_tag;
    logic        m_ovr, m_to, m_err, m_inflight;
    logic [31:0] m_pend;
    int          m_launches;
    logic [23:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_wdata;

    // Bus responder configuration.
    int          gnt_dly, rv_dly, rsp_w;
    logic        rsp_en, rsp_err;
    logic [31:0] rsp_data;

    task automatic model_reset();
        m_last_tag = 8'h00; m_ovr = 0; m_to = 0; m_err = 0;
        m_inflight = 0; m_pend = 32'h0;
    endtask

    task automatic model_frame(input logic [7:0] tag, input logic [23:0] addr,
                               input logic [1:0] op, input logic [31:0] din);
        if (m_inflight) begin
            m_ovr = 1;
        end else if (op != 2'b00 && tag != m_last_tag) begin
            m_last_tag = tag;
            m_inflight = 1;
            if (op == 2'b11) begin
                m_pend = {tag, 20'h0, m_ovr, m_to, m_err, 1'b0};
                m_ovr = 0; m_to = 0; m_err = 0;
            end else begin
                m_launches++;
                exp_addr  = {addr[23:2], 2'b00};
                exp_we    = (op == 2'b10);
                exp_wdata = din;
                if (!rsp_en || gnt_dly >= TO) begin
                    m_pend = 32'hDEAD_DEAD;
                    m_to   = 1;
                end else begin
                    if (op == 2'b01) m_pend = rsp_data;
                    if (rsp_err) m_err = 1;
                end
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] tag, input logic [23:0] addr,
                              input logic [1:0] op, input logic [31:0] din);
        @(negedge clk_i);
        ss_async_i = 1'b0;
        repeat (3) @(negedge clk_i);
        reg_addr_i = {tag, addr[23:2], op};
        reg_din_i  = din;
        ss_async_i = 1'b1;
        model_frame(tag, addr, op, din);
    endtask

    task automatic wait_done();
        int n;
        repeat (6) @(negedge clk_i);
        n = 0;
        while (busy_o && n < 80) begin
            @(negedge clk_i);
            n++;
        end
        check("idle_after_frame", busy_o, 0);
        m_inflight = 0;
        check("dout_after_frame", reg_dout_o, m_pend);
    endtask

    // Responder: grants after gnt_dly cycles, answers rv_dly cycles after the grant.
    initial begin
        bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0; bus_err_i = 0;
        forever begin
            @(negedge clk_i);
            if (bus_req_o === 1'b1) begin
                rsp_w = 0;
                while (rsp_w < gnt_dly && bus_req_o) begin
                    @(negedge clk_i);
                    rsp_w++;
                end
                if (bus_req_o) begin
                    bus_gnt_i = 1;
                    @(negedge clk_i);
                    bus_gnt_i = 0;
                    if (rsp_en) begin
                        repeat (rv_dly - 1) @(negedge clk_i);
                        bus_rvalid_i = 1; bus_rdata_i = rsp_data; bus_err_i = rsp_err;
                        @(negedge clk_i);
                        bus_rvalid_i = 0; bus_err_i = 0;
                    end
                end
            end
        end
    end

    // Per-cycle checker.
    int          req_rises = 0, req_len = 0, last_req_len = 0, ss_hi_cnt = 0;
    logic        req_prev = 0;
    logic [31:0] prev_dout = 0;
    logic [23:0] last_req_addr = 0;

    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (bus_req_o) begin
                check("bus_addr", {8'h0, bus_addr_o}, {8'h0, exp_addr});
                check("bus_we", bus_we_o, exp_we);
                check("bus_wdata", bus_wdata_o, exp_wdata);
                check("bus_be", bus_be_o, 4'hF);
                if (!req_prev) begin
                    req_rises++;
                    req_len = 0;
                    last_req_addr = bus_addr_o;
                end
                req_len++;
            end else if (req_prev) begin
                last_req_len = req_len;
            end
            if (reg_dout_o !== prev_dout) begin
                check("dout_change_value", reg_dout_o, m_pend);
                check("dout_change_ss_high", (ss_hi_cnt >= 2), 1);
            end
        end
        prev_dout = reg_dout_o;
        req_prev  = bus_req_o;
        ss_hi_cnt = ss_async_i ? ss_hi_cnt + 1 : 0;
    end

    initial begin
        reset_i = 1; ss_async_i = 1; reg_addr_i = 0; reg_din_i = 0;
        gnt_dly = 3; rv_dly = 2; rsp_en = 1; rsp_err = 0; rsp_data = 0;
        m_launches = 0; exp_addr = 0; exp_we = 0; exp_wdata = 0;
        model_reset();
        repeat (3) @(negedge clk_i);
        check("rst_req", bus_req_o, 0);
        check("rst_we", bus_we_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_addr", {8'h0, bus_addr_o}, 0);
        check("rst_wdata", bus_wdata_o, 0);
        check("rst_dout", reg_dout_o, 0);
        reset_i = 0;
        repeat (3) @(negedge clk_i);

        // Write
        send_frame(8'h01, 24'h000100, 2'b10, 32'hCAFE0001);
        wait_done();
        check("wr_req_count", req_rises, 1);
        check("wr_addr_lit", {8'h0, last_req_addr}, 32'h0000_0100);
        check("wr_dout_unchanged", reg_dout_o, 32'h0);

        // Read, then the same tag again
        rsp_data = 32'h1234_5678;
        send_frame(8'h02, 24'h000200, 2'b01, 32'h0);
        wait_done();
        check("rd_dout_lit", reg_dout_o, 32'h1234_5678);
        send_frame(8'h02, 24'h000200, 2'b01, 32'h0);
        wait_done();
        check("rd_repeat_no_req", req_rises, 2);
        check("req_count_model", req_rises, m_launches);

        // Timeout without grant, then with grant but no response
        gnt_dly = 100;
        send_frame(8'h03, 24'h000300, 2'b01, 32'h0);
        wait_done();
        check("to_req_len", last_req_len, TO);
        check("to_dout_lit", reg_dout_o, 32'hDEAD_DEAD);
        gnt_dly = 3; rsp_en = 0;
        send_frame(8'h06, 24'h000600, 2'b01, 32'h0);
        wait_done();
        check("to_gnt_dout_lit", reg_dout_o, 32'hDEAD_DEAD);
        rsp_en = 1;

        // Status reads: TO set, then cleared
        send_frame(8'h07, 24'h0, 2'b11, 32'h0);
        wait_done();
        check("stat1_lit", reg_dout_o, 32'h0700_0004);
        send_frame(8'h08, 24'h0, 2'b11, 32'h0);
        wait_done();
        check("stat2_lit", reg_dout_o, 32'h0800_0000);

        // Hold: response arrives while SS is low
        rv_dly = 8; rsp_data = 32'hA5A5_0009;
        send_frame(8'h09, 24'h000900, 2'b01, 32'h0);
        repeat (2) @(negedge clk_i);
        ss_async_i = 0;
        repeat (20) @(negedge clk_i);
        check("hold_busy", busy_o, 1);
        check("hold_dout_lit", reg_dout_o, 32'h0800_0000);
        ss_async_i = 1;
        model_frame(8'h09, 24'h000900, 2'b01, 32'h0);
        wait_done();
        check("hold_release_lit", reg_dout_o, 32'hA5A5_0009);

        // Overrun: frame tag 04 during WAIT of tag 0A (which also returns an error)
        gnt_dly = 1; rv_dly = 10; rsp_data = 32'h0000_000A; rsp_err = 1;
        send_frame(8'h0A, 24'h000A00, 2'b01, 32'h0);
        repeat (6) @(negedge clk_i);
        send_frame(8'h04, 24'h000400, 2'b01, 32'h0);
        wait_done();
        check("ovr_no_second_req", req_rises, 6);
        check("ovr_dout_lit", reg_dout_o, 32'h0000_000A);
        gnt_dly = 3; rv_dly = 2; rsp_err = 0; rsp_data = 32'h4444_4444;
        send_frame(8'h04, 24'h000400, 2'b01, 32'h0);
        wait_done();
        check("ovr_relaunch", req_rises, 7);
        check("ovr_relaunch_dout", reg_dout_o, 32'h4444_4444);
        send_frame(8'h0B, 24'h0, 2'b11, 32'h0);
        wait_done();
        check("stat3_lit", reg_dout_o, 32'h0B00_000A);

        // Asynchronous reset during REQ
        gnt_dly = 100;
        send_frame(8'h0C, 24'h000C00, 2'b01, 32'h0);
        repeat (6) @(negedge clk_i);
        check("pre_reset_req", bus_req_o, 1);
        #2 reset_i = 1;
        #1;
        check("async_rst_req", bus_req_o, 0);
        check("async_rst_busy", busy_o, 0);
        check("async_rst_dout", reg_dout_o, 0);
        model_reset();
        @(negedge clk_i);
        reset_i = 0;
        repeat (3) @(negedge clk_i);
        gnt_dly = 3; rsp_data = 32'hC0C0_C0C0;
        send_frame(8'h0C, 24'h000C00, 2'b01, 32'h0);
        wait_done();
        check("post_rst_relaunch", req_rises, 9);
        check("post_rst_dout", reg_dout_o, 32'hC0C0_C0C0);
        check("req_count_final", req_rises, m_launches);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
